// File: rtl/ds_adc_pkg.sv
// Shared definitions for the delta-sigma decimator: filter mode encoding,
// flush lengths and result-width derivation.
package ds_adc_pkg;

  typedef enum logic {
    SINC1 = 1'b0,
    SINC2 = 1'b1
  } mode_e;

  localparam logic [1:0] FLUSH_SINC1 = 2'd1;
  localparam logic [1:0] FLUSH_SINC2 = 2'd2;

  // Wide enough for R^2 with R up to 2^osr_w.
  function automatic int data_width(input int osr_w);
    return 2 * osr_w + 1;
  endfunction

  function automatic logic [1:0] flush_frames(input logic mode);
    return (mode == SINC2) ? FLUSH_SINC2 : FLUSH_SINC1;
  endfunction

endpackage

// File: rtl/ds_sinc_chan.sv
// One bitstream channel: sinc1 accumulator plus sinc2 integrator/comb cascade,
// result presented combinationally during the frame-end cycle.
module ds_sinc_chan
  import ds_adc_pkg::*;
#(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              bs,
  input  logic              frame_end,
  input  logic              mode,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] acc_p0, int1_p0, int2_p0, dly1_p1, dly2_p1;
  logic [DATA_W-1:0] acc_nxt, int1_nxt, int2_nxt, comb1, comb2;

  // All sums wrap modulo 2^DATA_W; the comb differences undo the wrap.
  always_comb begin
    acc_nxt  = acc_p0 + DATA_W'(bs);
    int1_nxt = int1_p0 + DATA_W'(bs);
    int2_nxt = int2_p0 + int1_nxt;
    comb1    = int2_nxt - dly1_p1;
    comb2    = comb1 - dly2_p1;
    result   = (mode == SINC2) ? comb2 : acc_nxt;
  end

  // input-rate integrators (p0) / frame-rate comb delays (p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      int1_p0 <= '0;
      int2_p0 <= '0;
      dly1_p1 <= '0;
      dly2_p1 <= '0;
    end else if (ena) begin
      acc_p0  <= frame_end ? '0 : acc_nxt;
      int1_p0 <= int1_nxt;
      int2_p0 <= int2_nxt;
      if (frame_end) begin
        dly1_p1 <= int2_nxt;
        dly2_p1 <= comb1;
      end
    end
  end

endmodule

// File: rtl/ds_decim_multi.sv
// Multi-channel sinc1/sinc2 decimator: shared frame/config/flush control,
// per-channel filters, holding bank and a lowest-channel-first drain stream.
module ds_decim_multi
  import ds_adc_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int OSR_W  = 8,
  localparam int DATA_W = data_width(OSR_W),
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NCH-1:0]    bs_in,
  input  logic [NCH-1:0]    ch_en,
  input  logic [OSR_W-1:0]  osr,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [NCH-1:0]    overrun,
  input  logic              ovr_clr
);

  logic [OSR_W-1:0] phase, act_osr, cfg_osr;
  logic             act_mode, cfg_mode;
  logic [1:0]       flush_cnt, flush_eff;
  logic             frame_start, cfg_changed, frame_end, res_write;

  // At phase 0 the incoming config already governs this frame (matters for R=1).
  always_comb begin
    frame_start = ena && (phase == '0);
    cfg_osr     = (phase == '0) ? osr : act_osr;
    cfg_mode    = (phase == '0) ? mode : act_mode;
    cfg_changed = frame_start && ((osr != act_osr) || (mode != act_mode));
    flush_eff   = cfg_changed ? flush_frames(mode) : flush_cnt;
    frame_end   = ena && (phase == cfg_osr);
    res_write   = frame_end && (flush_eff == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= '0;
      act_osr   <= osr;
      act_mode  <= mode;
      flush_cnt <= flush_frames(mode);
    end else if (ena) begin
      if (frame_start) begin
        act_osr  <= osr;
        act_mode <= mode;
      end
      phase     <= frame_end ? '0 : phase + 1'b1;
      flush_cnt <= (frame_end && flush_eff != 2'd0) ? flush_eff - 2'd1 : flush_eff;
    end
  end

  logic [DATA_W-1:0] res [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    ds_sinc_chan #(.DATA_W(DATA_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .bs        (bs_in[c]),
      .frame_end (frame_end),
      .mode      (cfg_mode),
      .result    (res[c])
    );
  end

  logic [NCH-1:0]    pending, wr_mask, xfer_oh, new_ovr;
  logic [DATA_W-1:0] hold_p1 [NCH];
  logic [CH_W-1:0]   low_ch, lock_ch;
  logic              lock, xfer;

  // A stalled channel stays presented even if a lower channel becomes pending.
  always_comb begin
    low_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) low_ch = CH_W'(i);
    end
    out_valid = |pending;
    out_ch    = lock ? lock_ch : low_ch;
    out_data  = hold_p1[out_ch];
    xfer      = out_valid && out_ready;
    xfer_oh   = '0;
    if (xfer) xfer_oh[out_ch] = 1'b1;
    wr_mask   = res_write ? ch_en : '0;
    new_ovr   = wr_mask & pending & ~xfer_oh;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else begin
      pending <= (pending & ~xfer_oh) | wr_mask;
      overrun <= (overrun & ~{NCH{ovr_clr}}) | new_ovr;
      if (xfer) begin
        lock <= 1'b0;
      end else if (out_valid) begin
        lock    <= 1'b1;
        lock_ch <= out_ch;
      end
    end
  end

  // holding bank (p1): one result per channel, overwritten on each frame end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) hold_p1[c] <= '0;
      else if (wr_mask[c]) hold_p1[c] <= res[c];
    end
  end

endmodule

// File: tb/tb_ds_decim_multi.sv
// Self-checking bench for ds_decim_multi: cycle-by-cycle reference model with
// filter results computed directly as windowed sums over the sample history.
module tb_ds_decim_multi;

  logic        clk = 1'b0;
  logic        rst_n, ena, mode, out_valid, out_ready, ovr_clr;
  logic [3:0]  bs_in, ch_en, overrun;
  logic [7:0]  osr;
  logic [16:0] out_data;
  logic [1:0]  out_ch;

  ds_decim_multi #(.NCH(4), .OSR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bs_in(bs_in), .ch_en(ch_en),
    .osr(osr), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [3:0]  hq[$];
  int          m_phase, m_osr, m_mode, m_flush, m_lch;
  logic [3:0]  m_pend, m_ovr;
  bit          m_lock, m_ok = 0;
  logic [16:0] m_bank[4];

  bit          pat;
  int          pcnt = 0;
  int          seen_cnt[4];
  logic [16:0] last_seen[4];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // sinc1: sum of the frame's R bits; sinc2: triangular window of 2R-1 bits.
  function automatic logic [16:0] model_res(int c, int r, int md);
    int n = hq.size();
    longint s = 0;
    int lim = (md != 0) ? 2 * r - 1 : r;
    for (int m = 0; m < lim; m++) begin
      if (m < n && hq[n-1-m][c]) s += (md == 0) ? 1 : ((m < r) ? m + 1 : 2 * r - 1 - m);
    end
    return s[16:0];
  endfunction

  function automatic int m_out_ch();
    int lo = 0;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) lo = i;
    return m_lock ? m_lch : lo;
  endfunction

  task automatic model_step();
    logic [3:0] xo, wr, nov;
    bit v;
    int ch;
    xo = '0;
    wr = '0;
    if (!rst_n) begin
      m_phase = 0; m_osr = int'(osr); m_mode = int'(mode);
      m_flush = mode ? 2 : 1;
      hq.delete();
      m_pend = '0; m_ovr = '0; m_lock = 0; m_lch = 0;
      for (int c = 0; c < 4; c++) m_bank[c] = '0;
      m_ok = 1;
      return;
    end
    v = |m_pend;
    ch = m_out_ch();
    if (v && out_ready) xo[ch] = 1'b1;
    if (ena) begin
      if (m_phase == 0) begin
        if (int'(osr) != m_osr || int'(mode) != m_mode) m_flush = mode ? 2 : 1;
        m_osr = int'(osr);
        m_mode = int'(mode);
      end
      hq.push_back(bs_in);
      if (hq.size() > 600) void'(hq.pop_front());
      if (m_phase == m_osr) begin
        if (m_flush > 0) m_flush--;
        else wr = ch_en;
        for (int c = 0; c < 4; c++) if (wr[c]) m_bank[c] = model_res(c, m_osr + 1, m_mode);
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
    nov = wr & m_pend & ~xo;
    if (v && !out_ready) begin
      m_lock = 1; m_lch = ch;
    end else if (v) begin
      m_lock = 0;
    end
    m_pend = (m_pend & ~xo) | wr;
    m_ovr = (ovr_clr ? 4'h0 : m_ovr) | nov;
  endtask

  task automatic cycle();
    if (pat) bs_in = {1'(pcnt % 4 == 0), 1'b0, 1'(pcnt % 2), 1'b1};
    if (out_valid === 1'b1 && out_ready) begin
      seen_cnt[out_ch]++;
      last_seen[out_ch] = out_data;
    end
    @(posedge clk);
    model_step();
    if (ena) pcnt++;
    #1;
    if (m_ok) begin
      total++;
      if (out_valid !== (|m_pend) || overrun !== m_ovr ||
          ((|m_pend) && (int'(out_ch) != m_out_ch() || out_data !== m_bank[m_out_ch()]))) begin
        bad++;
        if (bad < 20)
          $display("FAIL model t=%0t actual v=%b ch=%0d d=%0d ov=%h required v=%b ch=%0d d=%0d ov=%h",
                   $time, out_valid, out_ch, out_data, overrun, |m_pend, m_out_ch(),
                   m_bank[m_out_ch()], m_ovr);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr_seen();
    for (int c = 0; c < 4; c++) begin
      seen_cnt[c] = 0;
      last_seen[c] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
    clr_seen();
  endtask

  typedef struct packed {
    logic [7:0]       osr;
    logic             md;
    logic [3:0][16:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{osr: 8'd15, md: 1'b0, exp: {17'd4,   17'd0, 17'd8,   17'd16}};
    tbl[1] = '{osr: 8'd15, md: 1'b1, exp: {17'd64,  17'd0, 17'd128, 17'd256}};
    tbl[2] = '{osr: 8'd7,  md: 1'b0, exp: {17'd2,   17'd0, 17'd4,   17'd8}};
    tbl[3] = '{osr: 8'd7,  md: 1'b1, exp: {17'd16,  17'd0, 17'd32,  17'd64}};
    tbl[4] = '{osr: 8'd31, md: 1'b0, exp: {17'd8,   17'd0, 17'd16,  17'd32}};
    tbl[5] = '{osr: 8'd31, md: 1'b1, exp: {17'd256, 17'd0, 17'd512, 17'd1024}};

    rst_n = 1'b0; ena = 1'b1; bs_in = '0; ch_en = 4'hF; osr = 8'd15; mode = 1'b0;
    out_ready = 1'b1; ovr_clr = 1'b0; pat = 1'b1;

    do_reset(2);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_data", int'(out_data), 0);

    // steady-state results per config, after the flush frames
    for (int t = 0; t < 6; t++) begin
      osr = tbl[t].osr;
      mode = tbl[t].md;
      do_reset(2);
      run(4 * (int'(tbl[t].osr) + 1) + 5);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("tbl%0d_ch%0d_data", t, c), int'(last_seen[c]), int'(tbl[t].exp[c]));
        chk($sformatf("tbl%0d_ch%0d_count", t, c), seen_cnt[c], tbl[t].md ? 2 : 3);
      end
    end

    // mid-frame osr change
    osr = 8'd15; mode = 1'b0;
    do_reset(1);
    run(37);
    clr_seen();
    osr = 8'd7;
    run(16);
    chk("cfgchg_cnt1", seen_cnt[0], 1);
    chk("cfgchg_r16", int'(last_seen[0]), 16);
    run(16);
    chk("cfgchg_cnt2", seen_cnt[0], 2);
    chk("cfgchg_r8", int'(last_seen[0]), 8);

    // overrun and clear
    osr = 8'd15;
    do_reset(1);
    run(16);
    out_ready = 1'b0;
    run(16);
    chk("ovr_after_first", int'(overrun), 0);
    run(16);
    chk("ovr_after_second", int'(overrun), 15);
    chk("ovr_valid", int'(out_valid), 1);
    chk("ovr_ch", int'(out_ch), 0);
    chk("ovr_data", int'(out_data), 16);
    ovr_clr = 1'b1;
    run(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);
    out_ready = 1'b1;
    run(8);

    // masking with toggling backpressure
    ch_en = 4'b0101;
    do_reset(1);
    for (int i = 0; i < 85; i++) begin
      out_ready = 1'(i % 2);
      cycle();
    end
    out_ready = 1'b1;
    chk("mask_ch0_cnt", seen_cnt[0], 4);
    chk("mask_ch1_cnt", seen_cnt[1], 0);
    chk("mask_ch2_cnt", seen_cnt[2], 4);
    chk("mask_ch3_cnt", seen_cnt[3], 0);
    chk("mask_ch0_data", int'(last_seen[0]), 16);
    chk("mask_overrun", int'(overrun), 0);
    ch_en = 4'hF;

    // ena freeze mid-frame
    do_reset(1);
    run(37);
    clr_seen();
    ena = 1'b0;
    run(10);
    ena = 1'b1;
    run(16);
    chk("ena_cnt", seen_cnt[0], 1);
    chk("ena_data", int'(last_seen[0]), 16);

    // reset mid-frame
    run(7);
    rst_n = 1'b0;
    run(1);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_data", int'(out_data), 0);
    rst_n = 1'b1;
    clr_seen();
    run(21);
    chk("midrst_flush", seen_cnt[0], 0);
    run(16);
    chk("midrst_cnt", seen_cnt[0], 1);
    chk("midrst_data1", int'(last_seen[0]), 16);

    // randomized traffic against the model
    pat = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) begin
        case ($urandom_range(0, 6))
          0: osr = 8'd0;
          1: osr = 8'd1;
          2: osr = 8'd2;
          3: osr = 8'd3;
          4: osr = 8'd5;
          5: osr = 8'd7;
          default: osr = 8'd15;
        endcase
        mode = 1'($urandom_range(0, 1));
        ch_en = 4'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 799) != 0);
      ena = ($urandom_range(0, 7) != 0);
      out_ready = ((i / 200) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      ovr_clr = ($urandom_range(0, 49) == 0);
      bs_in = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ds_decim_multi.md
Name: ds_decim_multi

Overview:
- Multi-channel decimator for 1-bit comparator delta-sigma bitstreams, one per ui_in-style input pin.
- Runtime-selectable sinc1/sinc2 filter with a programmable oversampling ratio R.
- Per-channel results are buffered and drained over a single valid/ready stream tagged with channel number.
- Sits between the comparator/bitstream inputs and the output mux/serialiser of the top-level ADC.

Parameters:
- NCH, 4, number of bitstream channels (1..8)
- OSR_W, 8, width of osr field; R = osr+1, range 1..2^OSR_W
- DATA_W, 2*OSR_W+1, result width (holds R^2 max); derived, not overridden
- CH_W, max(1,$clog2(NCH)), channel tag width; derived

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  global enable; low freezes all filter/phase state (output stream still drains)
- bs_in  in  NCH  bitstreams, bit 1 = +1, bit 0 = 0
- ch_en  in  NCH  per-channel result enable
- osr  in  OSR_W  decimation ratio minus one
- mode  in  1  0 = sinc1, 1 = sinc2
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  unsigned filtered result
- out_ch  out  CH_W  channel of out_data
- overrun  out  NCH  sticky per-channel overrun flags
- ovr_clr  in  1  clears all overrun flags

Behaviour:
- Reset (rst_n low at posedge): phase counter, integrators, combs, holding bank, pending flags, overrun, out_valid all 0; active config = osr/mode inputs; flush counter armed (see below).
- Config latch: osr/mode sampled into active config only on the cycle the phase counter is 0 with ena high (frame start). Mid-frame changes have no effect until the next frame.
- Phase counter: advances on each ena cycle; wraps R-1 -> 0. The cycle at phase R-1 is frame end; that cycle's bit is included in the frame.
- sinc1: per-channel accumulator adds bs bit; at frame end, result = sum of the frame's R bits (0..R); accumulator restarts with the next sample.
- sinc2: two cascaded integrators at input rate and two combs at frame rate; all arithmetic is modulo 2^DATA_W (wrap intended). Steady-state constant-1 input gives R^2.
- Flush: after reset, and after any frame start where active osr or mode changed, the next 1 (sinc1) or 2 (sinc2) frame results are discarded: no pending set, no overrun.
- Frame end with ena: for each channel with ch_en set, result is written into the holding bank on the next posedge and pending[ch] is set. If pending[ch] was still set, overrun[ch] is set and the new value overwrites.
- Drain: out_valid = any pending. out_ch = lowest pending channel; out_data = its holding value. Transfer occurs when out_valid && out_ready, and clears that pending bit. At most one transfer per cycle.
- Latency: out_valid rises in the cycle after the posedge following the last sample.
- Stability: out_data/out_ch are stable while out_valid && !out_ready, except when a frame-end overwrite hits the presented channel. In that case data updates and overrun flags the loss.
- Simultaneous events:
  - A transfer and a frame-end write to the same channel in one cycle: the write wins (pending stays 1) and no overrun is flagged.
  - ovr_clr and a new overrun in the same cycle: the flag is set.
- ena low: phase and filter state hold; the drain continues.
- ch_en low: channel filter still runs, but no pending/overrun is generated.
- Reset mid-frame: all state returns to reset values; the partial frame is lost.

Decomposition:
- Shared package ds_adc_pkg:
  - mode encodings SINC1/SINC2
  - flush-frame constants (1, 2)
  - helper for the DATA_W derivation
- One sub-module ds_sinc_chan: per-channel integrators, combs and sinc1/sinc2 select, instantiated NCH times.
- Phase/config/flush control and the drain arbiter stay in the top module.

Test Plan:
- Basic sinc1: NCH=4, osr=15, mode=0, ch_en=4'hF, out_ready=1; ch0=1, ch1 toggling, ch2=0, ch3=1-in-4 -> after the flush frame, each frame emits ch0=16, ch1=8, ch2=0, ch3=4, in channel order.
- Sinc2 settling: osr=15, mode=1, ch0=1, ch1 toggling -> first two frames produce no output; then ch0=256 and ch1=128 every frame.
- Mid-frame config change: switch osr 15->7 at phase 5 -> current frame completes at R=16; next frame discarded (flush); later ch0 results = 8 (sinc1).
- Overrun: out_ready=0 for 2 frames, osr=15 -> overrun=4'hF after the second frame end, out_data holds the newest value; ovr_clr pulse -> overrun=0.
- Backpressure/masking: ch_en=4'b0101, out_ready toggling every cycle -> only ch0/ch2 are emitted; data is stable while stalled; no overrun.
- Enable/reset: ena low for 10 cycles mid-frame extends the frame with no result change (ch0 still 16). rst_n low mid-frame -> outputs 0; first valid result arrives after the flush frame.
